// File: rtl/sha256_msg_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sha256_msg_feeder                                            |
// | Description : Accepts a byte stream and emits SHA-256 padded 32-bit words, |
// |               16 per 512-bit block, for a compression core.                |
// |               Padding: 0x80, 0x00 fill to byte 56 of a block, then the     |
// |               64-bit big-endian message bit length.                        |
// | Ports       : clk, reset (async, active-low)                               |
// |               in_data/in_valid/in_last/in_empty/in_ready : byte input      |
// |               out_w/out_valid/out_ready                  : word output     |
// |               out_idx/out_first/out_final                : word position   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sha256_msg_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output logic [31:0] out_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_first,
  output logic        out_final
);

  typedef enum logic [2:0] {
    S_DATA  = 3'd0,
    S_PAD80 = 3'd1,
    S_ZERO  = 3'd2,
    S_LEN   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam logic [5:0] C_LEN_POS  = 6'd56;
  localparam logic [5:0] C_LAST_POS = 6'd63;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_alive;       // low until the first edge after reset release
  logic [60:0] r_byte_cnt;
  logic [5:0]  r_pos;         // byte position within the 64-byte block
  logic [31:0] r_pack;
  logic        r_full;        // r_pack holds a completed word not yet moved out
  logic        r_full_final;
  logic [31:0] r_out_w;
  logic        r_out_valid;
  logic [3:0]  r_out_idx;
  logic        r_out_final;

  logic        w_in_ready;
  logic        w_pack;
  logic [7:0]  w_pack_byte;
  logic        w_count;
  logic        w_load;
  logic        w_out_xfer;
  logic        w_done;
  logic        w_has_byte;
  logic [63:0] w_bit_len;
  logic [5:0]  w_len_base;

  assign w_bit_len  = {r_byte_cnt, 3'b000};
  // Length is emitted MSB first: position 56 carries bits 63:56.
  assign w_len_base = {3'd7 - r_pos[2:0], 3'b000};
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_load     = r_full && (!r_out_valid || out_ready);
  assign w_done     = (r_state == S_FLUSH) && w_out_xfer && r_out_final;
  // in_ready depends only on registers, so out_ready never reaches it.
  assign w_in_ready = r_alive && (r_state == S_DATA) && !r_full;
  // An empty beat only carries meaning as a message terminator.
  assign w_has_byte = !(in_last && in_empty);

  assign in_ready  = w_in_ready;
  assign out_w     = r_out_w;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_first = r_out_valid && (r_out_idx == 4'd0);
  assign out_final = r_out_final;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_DATA;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pack       = 1'b0;
    w_pack_byte  = 8'h00;
    w_count      = 1'b0;
    case (r_state)
      S_DATA: begin
        if (in_valid && w_in_ready) begin
          if (w_has_byte) begin
            w_pack      = 1'b1;
            w_pack_byte = in_data;
            w_count     = 1'b1;
          end
          if (in_last) begin
            w_next_state = S_PAD80;
          end
        end
      end
      S_PAD80: begin
        if (!r_full) begin
          w_pack       = 1'b1;
          w_pack_byte  = 8'h80;
          w_next_state = S_ZERO;
        end
      end
      S_ZERO: begin
        // Positions beyond 56 wrap through 63 -> 0 into an extra block.
        if (r_pos == C_LEN_POS) begin
          w_next_state = S_LEN;
        end else if (!r_full) begin
          w_pack = 1'b1;
        end
      end
      S_LEN: begin
        if (!r_full) begin
          w_pack      = 1'b1;
          w_pack_byte = w_bit_len[w_len_base +: 8];
          if (r_pos == C_LAST_POS) begin
            w_next_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (w_done) begin
          w_next_state = S_DATA;
        end
      end
      default: begin
        w_next_state = S_DATA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive      <= 1'b0;
      r_byte_cnt   <= '0;
      r_pos        <= '0;
      r_pack       <= '0;
      r_full       <= 1'b0;
      r_full_final <= 1'b0;
      r_out_w      <= '0;
      r_out_valid  <= 1'b0;
      r_out_idx    <= '0;
      r_out_final  <= 1'b0;
    end else begin
      r_alive <= 1'b1;

      // Packing only happens while r_full is low, so it never collides
      // with the load below that clears r_full.
      if (w_pack) begin
        r_pack <= {r_pack[23:0], w_pack_byte};
        r_pos  <= r_pos + 6'd1;
        if (r_pos[1:0] == 2'b11) begin
          r_full       <= 1'b1;
          r_full_final <= (r_state == S_LEN) && (r_pos == C_LAST_POS);
        end
      end

      if (w_count) begin
        r_byte_cnt <= r_byte_cnt + 61'd1;
      end

      if (w_load) begin
        r_full      <= 1'b0;
        r_out_w     <= r_pack;
        r_out_valid <= 1'b1;
        r_out_final <= r_full_final;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_final <= 1'b0;
      end

      if (w_out_xfer) begin
        r_out_idx <= r_out_idx + 4'd1;
      end

      if (w_done) begin
        r_byte_cnt <= '0;
        r_pos      <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sha256_msg_feeder.md
SHA256_MSG_FEEDER -- requirements
Module: sha256_msg_feeder

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset; ports SHALL be listed clock and reset first, as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-004 in_data  input  8  message byte.
REQ-005 in_valid  input  1  in_data, in_last and in_empty are valid.
REQ-006 in_last  input  1  the current beat ends the message.
REQ-007 in_empty  input  1  qualifies in_last: the beat carries no byte (zero-length message or trailing marker).
REQ-008 in_ready  output  1  the block accepts the beat this cycle.
REQ-009 out_w  output  32  padded message word, big-endian (first byte in bits 31:24), driving the compression core's in_w.
REQ-010 out_valid  output  1  out_w and all out_* flags are valid.
REQ-011 out_ready  input  1  the consumer takes the word this cycle.
REQ-012 out_idx  output  4  word index within the 512-bit block, 0..15.
REQ-013 out_first  output  1  out_idx==0.
REQ-014 out_final  output  1  the current word is word 15 of the message's last block.

Function
REQ-015 A transfer SHALL occur on a cycle with valid&&ready on that side; no combinational path SHALL exist from out_ready to in_ready.
REQ-016 States SHALL be: DATA, PAD80, ZERO, LEN, FLUSH; reset SHALL enter DATA.
REQ-017 DATA: in_ready=1 whenever the byte packer is not holding a completed, unsent word; each accepted non-empty byte SHALL be packed MSB-first and SHALL increment a 61-bit byte counter (wraps modulo 2^61).
REQ-018 A beat with in_last=1 and in_empty=0 SHALL be packed, then the state SHALL go to PAD80; a beat with in_last=1 and in_empty=1 SHALL pack nothing and go to PAD80.
REQ-019 PAD80: exactly one byte 0x80 SHALL be packed; next state is ZERO.
REQ-020 ZERO: 0x00 bytes SHALL be packed, one per cycle, until the block byte position equals 56; a position past 56 SHALL wrap through a full extra block before reaching 56. Next state is LEN.
REQ-021 LEN: the 64-bit bit length (byte_count<<3), big-endian, SHALL be packed as 8 bytes at positions 56..63; next state is FLUSH.
REQ-022 FLUSH: once word 15 has been transferred, the byte counter and block position SHALL clear and the state SHALL return to DATA.
REQ-023 in_ready SHALL be 0 in PAD80, ZERO, LEN and FLUSH.
REQ-024 Internal byte generation SHALL be 1 byte/cycle; a word SHALL enter the one-deep output register the cycle after its 4th byte is packed.
REQ-025 While out_valid=1 and out_ready=0, out_w, out_idx, out_first and out_final SHALL hold stable and packing SHALL stall after the next word completes.
REQ-026 out_idx SHALL increment on each output transfer and wrap from 15 to 0.
REQ-027 out_final SHALL be 1 only on the word 15 produced by LEN.
REQ-028 A new message's bytes SHALL NOT be accepted before out_final of the previous message has been transferred.

Reset
REQ-029 On reset=0: in_ready=0, out_valid=0, out_w=0, out_idx=0, out_first=0, out_final=0, byte counter=0, state=DATA, and any partial message SHALL be discarded.
REQ-030 in_ready SHALL rise no earlier than the first clk edge after reset deasserts.
REQ-031 Reset asserted mid-message or mid-padding SHALL abort the message with no further output words.

Verification
REQ-032 "abc" (0x61,0x62,0x63 with last on 0x63), out_ready=1 -> 16 words: 0x61626380, 0x00000000 x14, 0x00000018; out_final on word 15 only.
REQ-033 Zero-length message (in_last=1, in_empty=1) -> 0x80000000, 14 zero words, 0x00000000; out_final=1 on idx 15.
REQ-034 55 bytes of 0x41 -> one block; word 13=0x41414180, word 14=0x00000000, word 15=0x000001B8.
REQ-035 56 bytes of 0x41 -> two blocks; block 1 word 14=0x80000000, word 15=0x00000000, out_final=0; block 2 words 0..13=0, word 14=0, word 15=0x000001C0, out_final=1.
REQ-036 "abc" with out_ready toggled randomly (50%) -> identical word sequence to REQ-032, no word dropped or duplicated, outputs stable while stalled.
REQ-037 Reset pulsed after the 2nd output word of a 100-byte message -> all outputs equal their reset values; a following "abc" message produces exactly the REQ-032 output.
